// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared ALU control codes, op encodings and sequencer states
package muldiv_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULTU/DIVU over the shared ALU; signed MULT/DIV when MULDIV_SIGNED_EN is defined
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic         flush,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic [W-1:0] alu_in1,
    output logic [W-1:0] alu_in2,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_result,
    output logic         alu_own,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(ITER);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [W-1:0]  a_q, a_d, ph_q, ph_d, pl_q, pl_d, hi_q, hi_d, lo_q, lo_d;
    logic          is_div_in, div0_in, sa_in, sb_in, last, carry, ge;
    logic [W-1:0]  abs_a, abs_b, rs;

`ifdef MULDIV_SIGNED_EN
    assign sa_in = op[1] & opa[W-1];
    assign sb_in = op[1] & opb[W-1];
`else
    assign sa_in = 1'b0;
    assign sb_in = 1'b0;
`endif

    assign is_div_in = (op == OP_DIVU) || (op == OP_DIV);
    assign div0_in   = is_div_in && (opb == '0);
    assign abs_a     = sa_in ? -opa : opa;
    assign abs_b     = sb_in ? -opb : opb;
    assign last      = cnt_q == CW'(ITER - 1);
    assign rs        = {ph_q[W-2:0], pl_q[W-1]};
    assign carry     = alu_result < ph_q;
    assign ge        = ph_q[W-1] | (rs >= a_q);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic; flush overrides everything including a same-cycle start
    always_comb begin
        state_d = state_q;
        if (flush) state_d = IDLE;
        else unique case (state_q)
            IDLE: if (start) state_d = div0_in ? DONE : RUN;
            RUN:  if (last) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    // outputs; ALU lines are zeroed whenever the sequencer does not own the ALU
    always_comb begin
        alu_own  = state_q == RUN;
        busy     = state_q != IDLE;
        done     = state_q == DONE;
        alu_in1  = alu_own ? (div_q ? rs : ph_q) : '0;
        alu_in2  = alu_own ? ((div_q || pl_q[0]) ? a_q : '0) : '0;
        alu_ctrl = alu_own ? (div_q ? ALU_SUB : ALU_ADD) : ALU_AND;
        div_zero = dz_q;
        hi       = hi_q;
        lo       = lo_q;
    end

    // datapath next values: operand latch, shift-add / restoring step, result load
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        dz_d  = dz_q;
        a_d   = a_q;
        ph_d  = ph_q;
        pl_d  = pl_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        unique case (state_q)
            IDLE: if (start && !flush) begin
                cnt_d = '0;
                div_d = is_div_in;
                sa_d  = sa_in;
                sb_d  = sb_in;
                a_d   = is_div_in ? abs_b : abs_a;
                pl_d  = is_div_in ? abs_a : abs_b;
                ph_d  = '0;
                if (div0_in) begin
                    hi_d = opa;
                    lo_d = '1;
                    dz_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                ph_d  = div_q ? (ge ? alu_result : rs) : {carry, alu_result[W-1:1]};
                pl_d  = div_q ? {pl_q[W-2:0], ge} : {alu_result[0], pl_q[W-1:1]};
            end
            FIX: if (!flush) begin
                if (div_q) begin
                    hi_d = sa_q ? -ph_q : ph_q;
                    lo_d = (sa_q ^ sb_q) ? -pl_q : pl_q;
                end else begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? -{ph_q, pl_q} : {ph_q, pl_q};
                end
            end
            DONE: dz_d = 1'b0;
        endcase
        if (flush) dz_d = 1'b0;
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= 1'b0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            dz_q  <= 1'b0;
            a_q   <= '0;
            ph_q  <= '0;
            pl_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            dz_q  <= dz_d;
            a_q   <= a_d;
            ph_q  <= ph_d;
            pl_q  <= pl_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random scoreboard bench with a behavioural shared ALU
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = '0, opb = '0;
    logic [31:0] alu_in1, alu_in2, alu_result, hi, lo;
    logic [3:0]  alu_ctrl;
    logic        alu_own, busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] last_hi = '0, last_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.W(32), .ITER(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
        .opa(opa), .opb(opb), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_own(alu_own),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_in1 & alu_in2;
            ALU_OR:  alu_result = alu_in1 | alu_in2;
            ALU_ADD: alu_result = alu_in1 + alu_in2;
            ALU_SUB: alu_result = alu_in1 - alu_in2;
            ALU_SLT: alu_result = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            ALU_NOR: alu_result = ~(alu_in1 | alu_in2);
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit sg;
        longint sa, sbv, p;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        e.dz = 1'b0;
        e.lat = 33;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        if (o[0] && b == 32'h0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dz = 1'b1;
            e.lat = 0;
        end else if (!o[0]) begin
            p = sa * sbv;
            up = {32'h0, a} * {32'h0, b};
            if (sg) up = 64'(p);
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (sg) begin
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int lat, own_n, sub_n;
        bit seen;
        sb.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; own_n = 0; sub_n = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (alu_own) own_n++;
                if (alu_own && alu_ctrl == ALU_SUB) sub_n++;
                @(posedge clk);
                lat++;
            end
        end
        e = sb.pop_front();
        chk({tag, "_done_seen"}, 64'(seen), 64'(1'b1));
        chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({tag, "_own_cycles"}, 64'(own_n), 64'(e.lat == 0 ? 0 : 32));
        if (o[0]) chk({tag, "_sub_cycles"}, 64'(sub_n), 64'(e.lat == 0 ? 0 : 32));
        @(posedge clk);
        #1;
        chk({tag, "_after_done"}, 64'({busy, done, div_zero}), 64'(3'b000));
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    initial begin
        int dn;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        #12;
        chk("reset_ctrl", 64'({busy, done, div_zero, alu_own, alu_ctrl}), 64'(8'h00));
        chk("reset_hilo", {hi, lo}, 64'(0));
        chk("reset_alu_in", {alu_in1, alu_in2}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_spec_hi", 64'(hi), 64'(32'hFFFFFFFE));
        run("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run("divu_zero", OP_DIVU, 32'h12345678, 32'h0);

        // flush mid-RUN: no done, hi/lo keep the previous result
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; opa = 32'd3; opb = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_in_run", 64'({busy, alu_own}), 64'(2'b11));
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", 64'({busy, alu_own, done}), 64'(3'b000));
        chk("flush_hilo", {hi, lo}, {last_hi, last_lo});
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("flush_no_done", 64'(dn), 64'(0));

        // start together with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULTU; opa = 32'd9; opb = 32'd9;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("start_flush_dropped", 64'(busy), 64'(1'b0));

        // second start while busy is ignored; async reset mid-RUN clears everything
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; opa = 32'd3; opb = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_DIVU; opa = 32'd50; opb = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored", 64'({busy, alu_own, div_zero, alu_ctrl}), 64'({1'b1, 1'b1, 1'b0, ALU_ADD}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({busy, done, div_zero, alu_own, alu_ctrl}), 64'(8'h00));
        chk("async_reset_data", {hi, lo}, 64'(0));
        chk("async_reset_alu_in", {alu_in1, alu_in2}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_no_queued_start", 64'(busy), 64'(1'b0));

        run("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
        chk("div_m7_2_spec", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
`else
        chk("div_m7_2_spec", {hi, lo}, {32'h00000001, 32'h7FFFFFFC});
`endif
        run("mult_m3_5", OP_MULT, 32'hFFFFFFFD, 32'd5);
        run("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9);
        run("div_m100_m7", OP_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run("divu_small_big", OP_DIVU, 32'd5, 32'h80000000);
        run("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'd1);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i == 3) rb = 32'h0;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            run("random", ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller that performs MIPS MULTU/DIVU by sequencing the existing shared 32-bit ALU for 32 iterations.
- Sequencing uses ALU add (ctrl 4'b0010) and sub (ctrl 4'b0110) and writes the HI/LO result registers.
- Sits beside the ALU in the execute stage; the main control stalls the pipeline while busy=1.
- ALU operand/control muxing is owned by this block whenever alu_own=1.

Parameters:
- W, 32, operand/result width; must match ALU width.
- ITER, 32, number of iteration cycles; must equal W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00=MULTU, 01=DIVU, 10=MULT, 11=DIV (signed codes per Optional Feature)
- flush  input  1  synchronous abort to IDLE
- opa  input  W  multiplicand / dividend
- opb  input  W  multiplier / divisor
- alu_in1  output  W  ALU operand 1 when alu_own=1
- alu_in2  output  W  ALU operand 2 when alu_own=1
- alu_ctrl  output  4  ALU control when alu_own=1
- alu_result  input  W  ALU ou
- alu_own  output  1  high while the sequencer drives the ALU
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle pulse; hi/lo valid
- div_zero  output  1  set with done when a divide had opb==0
- hi  output  W  HI register
- lo  output  W  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, div_zero, alu_own = 0; hi, lo, alu_in1, alu_in2 = 0; alu_ctrl = 4'b0000.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 latches opa, opb, op; iteration count cnt=0; go to RUN.
  - Exception: divide with opb==0 goes directly to DONE with hi=opa, lo=32'hFFFFFFFF, div_zero=1.
- RUN: exactly ITER cycles, alu_own=1.
  - Multiply (shift-add), with acc={P_hi,P_lo}, P_lo initialised to opb, P_hi to 0:
    - alu_in1=P_hi, alu_in2 = (P_lo[0] ? mcand : 0), alu_ctrl=ADD.
    - carry = (alu_result < alu_in1), computed as an unsigned local compare.
    - Next state of acc = {carry, alu_result, P_lo} >> 1.
  - Divide (restoring), R=0, Q=dividend initially:
    - R' = {R[W-2:0], Q[W-1]}; ovf = R[W-1].
    - alu_in1=R', alu_in2=divisor, alu_ctrl=SUB.
    - If ovf or R' >= divisor: R = alu_result and the shifted-in quotient bit = 1.
    - Otherwise: R = R' and the bit = 0.
    - Q shifts left.
  - cnt==ITER-1 moves to FIX.
- FIX: one cycle, alu_own=0.
  - hi/lo loaded: multiply hi=P_hi, lo=P_lo; divide hi=R, lo=Q.
  - Signed adjust applies only if the feature is enabled.
  - Then go to DONE.
- DONE: one cycle; done=1, busy=1; then IDLE. div_zero is cleared on leaving DONE.
- Latency: start accepted at edge N, done high in cycle N+34 (1 IDLE-accept, 32 RUN, 1 FIX).
  - Divide-by-zero: done high in cycle N+1.
- start while busy: ignored, no queuing.
- start and flush in the same IDLE cycle: flush wins; the request is dropped.
- flush in RUN/FIX/DONE: next state IDLE; busy, alu_own, done = 0; hi/lo keep their prior values.
- rst_n deasserted mid-operation: all state returns to reset values immediately.
- When alu_own=0, alu_in1/alu_in2/alu_ctrl are driven 0 so the external mux is don't-care.
- All arithmetic is modulo 2^W except the local carry and compare, which are unsigned.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects signed operation.
  - IDLE latches |opa| and |opb| (local two's-complement negate) plus the sign flags.
  - FIX negates the results:
    - MULT: negates the 64-bit product when sign_a^sign_b.
    - DIV: negates lo when sign_a^sign_b; negates hi when sign_a.
  - Same latency.
- Undefined: op[1] is ignored; every op is treated as unsigned.

Decomposition:
- Shared package muldiv_pkg:
  - ALU control constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - op encodings OP_MULTU/OP_DIVU/OP_MULT/OP_DIV.
  - State enum IDLE/RUN/FIX/DONE.
- No sub-module; the ALU stays an external shared instance. A testbench-only ALU model is instantiated beside the sequencer.

Test Plan:
- MULTU opa=32'hFFFFFFFF, opb=32'hFFFFFFFF -> done at cycle N+34, hi=32'hFFFFFFFE, lo=32'h00000001, div_zero=0.
- DIVU opa=100, opb=7 -> hi=2, lo=14; alu_ctrl=4'b0110 on all 32 RUN cycles.
- DIVU opa=32'h12345678, opb=0 -> done at N+1, div_zero=1, hi=32'h12345678, lo=32'hFFFFFFFF.
- MULTU 3*5 started, flush asserted at RUN cycle 10 -> IDLE next cycle, no done pulse, hi/lo unchanged from the prior result.
- start pulsed again while busy, then reset asserted mid-RUN -> second start ignored; all outputs 0 asynchronously on reset.
- With MULDIV_SIGNED_EN, DIV opa=-7, opb=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Without the macro, the same op gives an unsigned result: lo=32'h7FFFFFFC, hi=1.
